// File: rtl/min_search_sequencer.sv
// Streams candidate values through one shared minimum comparator.
// Reports the smallest value and the 0-based position where it first appears.
module min_search_sequencer #(
    parameter int IDX_W = 16,
    parameter int VAL_W = 14
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             iStart,
    input  logic [IDX_W-1:0] iCount,
    input  logic             iValid,
    input  logic [VAL_W-1:0] iValue,
    output logic             oReady,
    output logic             oBusy,
    output logic             oDone,
    output logic [IDX_W-1:0] oIndex,
    output logic [VAL_W-1:0] oValue
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, stateNext;
    logic [IDX_W-1:0] countReg;
    logic [IDX_W-1:0] posCnt;
    logic [IDX_W-1:0] minIdx;
    logic [VAL_W-1:0] minVal;
    logic             accept;
    logic             lastBeat;

    assign accept   = (state == RUN) && iValid;
    assign lastBeat = accept && (posCnt == countReg - IDX_W'(1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        oReady    = 1'b0;
        oBusy     = 1'b0;
        oDone     = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) stateNext = (iCount != '0) ? RUN : DONE;
            end
            RUN: begin
                oReady = 1'b1;
                oBusy  = 1'b1;
                if (lastBeat) stateNext = DONE;
            end
            DONE: begin
                oBusy     = 1'b1;
                oDone     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // All-ones seed with index 0 lets an all-max search report the first slot.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            countReg <= '0;
            posCnt   <= '0;
            minIdx   <= '0;
            minVal   <= '0;
        end else if (state == IDLE && iStart) begin
            countReg <= iCount;
            posCnt   <= '0;
            minVal   <= '1;
            minIdx   <= (iCount == '0) ? '1 : '0;
        end else if (accept) begin
            posCnt <= posCnt + IDX_W'(1);
            // Strict compare: ties keep the earlier index.
            if (iValue < minVal) begin
                minVal <= iValue;
                minIdx <= posCnt;
            end
        end
    end

    assign oIndex = minIdx;
    assign oValue = minVal;

endmodule

// File: tb/tb_min_search_sequencer.sv
// Randomized and directed checks of min_search_sequencer against a queue-based minimum model.
module tb_min_search_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        iStart = 1'b0;
    logic [15:0] iCount = '0;
    logic        iValid = 1'b0;
    logic [13:0] iValue = '0;
    logic        oReady, oBusy, oDone;
    logic [15:0] oIndex;
    logic [13:0] oValue;

    int checks = 0;
    int errors = 0;
    int lastIdx = 0;
    int lastVal = 0;

    min_search_sequencer #(.IDX_W(16), .VAL_W(14)) dut (
        .Clk(Clk), .Rst(Rst), .iStart(iStart), .iCount(iCount),
        .iValid(iValid), .iValue(iValue), .oReady(oReady), .oBusy(oBusy),
        .oDone(oDone), .oIndex(oIndex), .oValue(oValue)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: smallest value, earliest position; empty search gives the marker pair.
    function automatic void refMin(input int vals[$], output int idx, output int val);
        idx = 'hFFFF;
        val = 'h3FFF;
        if (vals.size() == 0) return;
        idx = 0;
        for (int i = 0; i < vals.size(); i++)
            if (vals[i] < vals[idx]) idx = i;
        val = vals[idx];
    endfunction

    // stall < 0 selects a random 0..2 gap before each beat.
    task automatic runSearch(input int vals[$], input int stall, input bit midStart);
        int expIdx, expVal, gap;
        refMin(vals, expIdx, expVal);
        @(negedge Clk);
        chk("idleBusy", oBusy, 0);
        chk("idleDone", oDone, 0);
        chk("holdIdx", oIndex, lastIdx);
        chk("holdVal", oValue, lastVal);
        iStart = 1'b1;
        iCount = 16'(vals.size());
        @(negedge Clk);
        iStart = 1'b0;
        iCount = 16'($urandom);
        for (int i = 0; i < vals.size(); i++) begin
            gap = (stall < 0) ? int'($urandom_range(2, 0)) : stall;
            for (int s = 0; s < gap; s++) begin
                chk("stallReady", oReady, 1);
                chk("runDone", oDone, 0);
                if (midStart && s == 0) begin
                    iStart = 1'b1;
                    iCount = 16'd1;
                end
                @(negedge Clk);
                iStart = 1'b0;
            end
            chk("beatReady", oReady, 1);
            chk("beatBusy", oBusy, 1);
            iValid = 1'b1;
            iValue = 14'(vals[i]);
            @(negedge Clk);
            iValid = 1'b0;
            iValue = 14'($urandom);
        end
        chk("done", oDone, 1);
        chk("doneReady", oReady, 0);
        chk("doneBusy", oBusy, 1);
        chk("resIdx", oIndex, expIdx);
        chk("resVal", oValue, expVal);
        lastIdx = expIdx;
        lastVal = expVal;
    endtask

    initial begin
        int q[$];
        int n;
        @(negedge Clk);
        chk("rstReady", oReady, 0);
        chk("rstBusy", oBusy, 0);
        chk("rstDone", oDone, 0);
        chk("rstIdx", oIndex, 0);
        chk("rstVal", oValue, 0);
        Rst = 1'b0;

        // Abandon a search after 3 beats.
        @(negedge Clk);
        iStart = 1'b1;
        iCount = 16'd5;
        @(negedge Clk);
        iStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iValid = 1'b1;
            iValue = 14'(7 - i);
            @(negedge Clk);
        end
        iValid = 1'b0;
        Rst = 1'b1;
        #1;
        chk("midRstReady", oReady, 0);
        chk("midRstBusy", oBusy, 0);
        chk("midRstDone", oDone, 0);
        chk("midRstIdx", oIndex, 0);
        chk("midRstVal", oValue, 0);
        @(negedge Clk);
        Rst = 1'b0;
        lastIdx = 0;
        lastVal = 0;

        runSearch('{9, 2}, 0, 1'b0);
        runSearch('{40, 12, 77, 12, 30}, 0, 1'b0);
        runSearch('{500, 3, 'h3FFF, 0}, 2, 1'b1);
        runSearch('{'h3FFF, 'h3FFF, 'h3FFF}, 0, 1'b0);
        runSearch('{0}, 0, 1'b0);
        q = {};
        runSearch(q, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            q = {};
            n = int'($urandom_range(12, 1));
            for (int i = 0; i < n; i++)
                q.push_back((t % 2) ? int'($urandom_range(5, 0)) : int'($urandom_range('h3FFF, 0)));
            runSearch(q, -1, t % 3 == 0);
        end

        @(negedge Clk);
        chk("finalDone", oDone, 0);
        chk("finalBusy", oBusy, 0);
        chk("finalIdx", oIndex, lastIdx);
        chk("finalVal", oValue, lastVal);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
